// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM pin bundle for sram_arbiter
interface sram_arbiter_if;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        host_req;
  logic        host_we;
  logic [17:0] host_addr;
  logic [15:0] host_wdata;
  logic [1:0]  host_be;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [17:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_drive;
  logic        ram_ce;
  logic        ram_oe;
  logic        ram_we;
  logic        ram_lb;
  logic        ram_hb;
  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, host_be, ram_din,
    input  vid_ack, vid_rdata, host_ack, host_rdata, ram_addr, ram_dout, ram_drive,
           ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );
  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, host_be, ram_din,
    output vid_ack, vid_rdata, host_ack, host_rdata, ram_addr, ram_dout, ram_drive,
           ram_ce, ram_oe, ram_we, ram_lb, ram_hb
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async 256Kx16 SRAM between the video fetch and host ports
module sram_arbiter #(
  parameter int ACCESS_CYCLES    = 2,
  parameter int WE_CYCLES        = 2,
  parameter int MAX_VIDEO_STREAK = 4
) (
  input logic           clk100,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  localparam int CW = $clog2((ACCESS_CYCLES > WE_CYCLES ? ACCESS_CYCLES : WE_CYCLES) + 1);
  localparam int SW = $clog2(MAX_VIDEO_STREAK + 1);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] streak, streak_n;
  logic          own_host, own_n;
  logic [1:0]    be, be_n;
  logic [17:0]   addr_n;
  logic [15:0]   dout_n, vrd_n, hrd_n;
  logic          vid_win, busy, wr;
  always_comb begin
    vid_win  = bus.vid_req && (!bus.host_req || streak < SW'(MAX_VIDEO_STREAK));
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    streak_n = streak;
    own_n    = own_host;
    be_n     = be;
    addr_n   = bus.ram_addr;
    dout_n   = bus.ram_dout;
    vrd_n    = bus.vid_rdata;
    hrd_n    = bus.host_rdata;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        streak_n = vid_win && bus.host_req ? streak + 1'b1 : '0;
        if (vid_win) begin
          state_n = RD;
          own_n   = 1'b0;
          addr_n  = bus.vid_addr;
        end else if (bus.host_req) begin
          state_n = bus.host_we ? WR_SETUP : RD;
          own_n   = 1'b1;
          addr_n  = bus.host_addr;
          be_n    = bus.host_be;
          dout_n  = bus.host_we ? bus.host_wdata : bus.ram_dout;
        end
      end
      RD: if (cnt == CW'(ACCESS_CYCLES - 1)) begin
        state_n = DONE;
        vrd_n   = own_host ? bus.vid_rdata : bus.ram_din;
        hrd_n   = own_host ? bus.ram_din : bus.host_rdata;
      end
      WR_SETUP: begin
        state_n = WR_PULSE;
        cnt_n   = '0;
      end
      WR_PULSE: state_n = cnt == CW'(WE_CYCLES - 1) ? WR_HOLD : WR_PULSE;
      WR_HOLD:  state_n = DONE;
      default:  state_n = IDLE;
    endcase
    busy = state_n inside {RD, WR_SETUP, WR_PULSE, WR_HOLD};
    wr   = state_n inside {WR_SETUP, WR_PULSE, WR_HOLD};
  end
  always_ff @(posedge clk100) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      streak         <= '0;
      own_host       <= 1'b0;
      be             <= '0;
      bus.ram_addr   <= '0;
      bus.ram_dout   <= '0;
      bus.ram_ce     <= 1'b1;
      bus.ram_oe     <= 1'b1;
      bus.ram_we     <= 1'b1;
      bus.ram_lb     <= 1'b1;
      bus.ram_hb     <= 1'b1;
      bus.ram_drive  <= 1'b0;
      bus.vid_ack    <= 1'b0;
      bus.host_ack   <= 1'b0;
      bus.vid_rdata  <= '0;
      bus.host_rdata <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      streak         <= streak_n;
      own_host       <= own_n;
      be             <= be_n;
      bus.ram_addr   <= addr_n;
      bus.ram_dout   <= dout_n;
      bus.ram_ce     <= !busy;
      bus.ram_oe     <= state_n != RD;
      bus.ram_we     <= state_n != WR_PULSE;
      bus.ram_lb     <= wr ? !be_n[0] : state_n != RD;
      bus.ram_hb     <= wr ? !be_n[1] : state_n != RD;
      bus.ram_drive  <= wr;
      bus.vid_ack    <= state_n == DONE && !own_n;
      bus.host_ack   <= state_n == DONE && own_n;
      bus.vid_rdata  <= vrd_n;
      bus.host_rdata <= hrd_n;
    end
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 256Kx16 asynchronous SRAM between two requesters.
  - Video port: background line fetch, latency-critical, default priority.
  - Host port: CPU/blitter, read and write, byte enables.
- Generates all SRAM pin timing in the clk100 domain.
- Sits between the background/fetch logic and the top-level SRAM pins.
- Top level owns the data-bus tristate, using ram_drive.

Parameters:
- ACCESS_CYCLES, 2, clk100 cycles that OE/CE are held per read before data capture (>=1).
- WE_CYCLES, 2, clk100 cycles of the active WE pulse per write (>=1).
- MAX_VIDEO_STREAK, 4, consecutive video grants allowed while a host request waits (>=1).

Ports:
- clk100  in  1  system clock; single clock domain.
- reset  in  1  synchronous reset, active-high.
- vid_req  in  1  video read request; held with vid_addr until vid_ack.
- vid_addr  in  18  video word address.
- vid_ack  out  1  one-cycle completion strobe; vid_rdata valid while high.
- vid_rdata  out  16  video read data.
- host_req  in  1  host request; held with its qualifiers until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  18  host word address.
- host_wdata  in  16  host write data.
- host_be  in  2  byte enables; [0] = low byte, [1] = high byte.
- host_ack  out  1  one-cycle completion strobe.
- host_rdata  out  16  host read data, valid while host_ack is high.
- ram_addr  out  18  SRAM address, registered.
- ram_din  in  16  SRAM read data.
- ram_dout  out  16  SRAM write data, registered.
- ram_drive  out  1  1 = top level drives ram_dout onto the bus.
- ram_ce  out  1  chip enable, active-low.
- ram_oe  out  1  output enable, active-low.
- ram_we  out  1  write enable, active-low.
- ram_lb  out  1  lower byte select, active-low.
- ram_hb  out  1  upper byte select, active-low.

Behaviour:
- All outputs are registered.
- Reset values: ram_ce/oe/we/lb/hb = 1; ram_addr = 0; ram_dout = 0; ram_drive = 0; vid_ack = host_ack = 0; vid_rdata = host_rdata = 0; streak = 0; state = IDLE.
- Reset asserted mid-access: pins return to idle on the next edge; no ack is issued. The requester re-issues after reset.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Requests are sampled only in IDLE.
- IDLE grant rule:
  - If vid_req and (!host_req or streak < MAX_VIDEO_STREAK): grant video.
  - Else if host_req: grant host.
  - Else stay in IDLE.
  - Video request and host request in the same cycle with streak below the limit: video wins.
- Streak counter:
  - Video grant while host_req is high: streak+1, saturating at MAX_VIDEO_STREAK.
  - Host grant, or host_req low in IDLE: streak = 0.
- Latched at grant: address, we, wdata, be.
- Read (video, or host with we=0), in RD for ACCESS_CYCLES cycles:
  - ram_addr = latched address; ce = 0; oe = 0; we = 1; lb = hb = 0 (word read regardless of be); drive = 0.
  - At the edge ending the last RD cycle, ram_din is captured into the owner's rdata.
  - Next state is DONE.
- Write:
  - WR_SETUP, 1 cycle: ce = 0, oe = 1, we = 1, lb = ~be[0], hb = ~be[1], ram_dout = wdata, drive = 1.
  - WR_PULSE, WE_CYCLES cycles: as WR_SETUP with we = 0.
  - WR_HOLD, 1 cycle: we = 1; address, data, byte selects and drive unchanged.
  - Next state is DONE.
  - be = 00: the full cycle still runs with lb = hb = 1; nothing is written; ack is issued normally.
- DONE, 1 cycle:
  - Owner's ack = 1; ce = oe = we = lb = hb = 1; drive = 0.
  - No grant is made in DONE. Next state is IDLE.
- Handshake:
  - A transaction completes at the edge where req and ack are both high.
  - A requester may keep req high with new qualifiers for a back-to-back transaction.
  - Qualifiers must be stable from req rise until ack.
- Occupancy, measured from the IDLE grant cycle to the IDLE cycle after DONE:
  - Read: ACCESS_CYCLES + 2 cycles.
  - Write: WE_CYCLES + 4 cycles.
- rdata registers hold their value until the next read for that port.
- ram_addr holds its last value between accesses.
- No ack is ever issued to a requester whose req was low at grant.

Test Plan:
- Video only: vid_req = 1, vid_addr = 0x00100, ram_din = 0xBEEF (default params) -> ce/oe low for exactly 2 cycles; vid_ack high 3 cycles after the grant cycle; vid_rdata = 0xBEEF; ram_we stays 1.
- Host write: host_we = 1, host_addr = 0x3FFFF, host_wdata = 0x1234, host_be = 10 -> WR_SETUP 1 cycle, we low 2 cycles, WR_HOLD 1 cycle; ram_hb = 0, ram_lb = 1; drive = 1 for 4 cycles; host_ack 1 cycle; 6-cycle occupancy.
- Contention: vid_req and host_req held continuously -> grant order V,V,V,V,H,V,V,V,V,H; each host read returns the correct ram_din.
- Simultaneous first request, streak 0 -> video granted first; host granted after the 4th video completion.
- Reset asserted during WR_PULSE -> next edge: ram_we = ram_ce = 1, drive = 0, no host_ack; after reset release a fresh write completes normally.
- host_be = 00 write, then back-to-back host read with req held high -> write has lb = hb = 1 throughout and ack issued; the read begins in the IDLE cycle right after DONE.
